regfile_mp: RTL

//  Parametrised multi-port general-purpose register file for the next CPU generation.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_clr_seq.sv | 62 ++++++
 rtl/regfile_mp.sv | 79 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the multi-port register file
package regfile_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int ZERO_ADDR = 0;

endpackage

// File: rtl/regfile_clr_seq.sv
// rtl/regfile_clr_seq.sv - soft-clear sequencer: walks every entry writing zero, flags dropped writes
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ena_i,
  input  logic              clr_req_i,
  input  logic              wr_req_i,
  output logic              busy_o,
  output logic              wr_drop_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              drop_q, drop_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    if (ena_i) begin
      case (state_q)
        RF_IDLE: begin
          if (clr_req_i) begin
            state_d = RF_CLEAR;
            cnt_d   = '0;
          end
        end
        RF_CLEAR: begin
          drop_d = wr_req_i;
          // The all-ones count is the terminal edge; the increment wraps back to 0 here.
          cnt_d  = cnt_q + 1'b1;
          if (&cnt_q) state_d = RF_IDLE;
        end
        default: state_d = RF_IDLE;
      endcase
    end
  end

  assign busy_o     = (state_q == RF_CLEAR);
  assign wr_drop_o  = drop_q;
  assign clr_we_o   = (state_q == RF_CLEAR) && ena_i;
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file: async reads with bypass, two prioritised write ports
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     reg_clock,
  input  logic                     rst,
  input  logic                     reg_ena,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     wr_drop
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok0, wr_ok1;

  regfile_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
    .clk_i      (reg_clock),
    .rst_i      (rst),
    .ena_i      (reg_ena),
    .clr_req_i  (clr_req),
    .wr_req_i   (we0 | we1),
    .busy_o     (busy),
    .wr_drop_o  (wr_drop),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // An accepted write is one that will land at this edge; bypass keys off the same terms.
  assign wr_ok0 = reg_ena && we0 && !busy && !((ZERO_REG != 0) && (waddr0 == ADDR_W'(ZERO_ADDR)));
  assign wr_ok1 = reg_ena && we1 && !busy && !((ZERO_REG != 0) && (waddr1 == ADDR_W'(ZERO_ADDR)));

  always_ff @(posedge reg_clock or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      if (clr_we) mem_q[clr_addr] <= '0;
      if (wr_ok0) mem_q[waddr0] <= wdata0;
      if (wr_ok1) mem_q[waddr1] <= wdata1;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_val;

    assign ra = raddr[i*ADDR_W +: ADDR_W];

    always_comb begin
      rd_val = '0;
      if (reg_ena) begin
        if ((ZERO_REG != 0) && (ra == ADDR_W'(ZERO_ADDR))) rd_val = '0;
        else if ((BYPASS != 0) && wr_ok1 && (waddr1 == ra)) rd_val = wdata1;
        else if ((BYPASS != 0) && wr_ok0 && (waddr0 == ra)) rd_val = wdata0;
        else rd_val = mem_q[ra];
      end
    end

    assign rdata[i*DATA_W +: DATA_W] = rd_val;
  end

endmodule
